// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: MSB-first bits framed by a start strobe, words held behind
// a valid/ready handshake with a sticky overrun flag. Define SIPO_PARITY_EN for even-parity check.
module sipo_deserializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    input  logic                  frame,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  parity_err
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StShift  = 2'd1;
`ifdef SIPO_PARITY_EN
    localparam logic [1:0] StParity = 2'd2;
`endif

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  commit;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  accept, drop;

`ifdef SIPO_PARITY_EN
    logic word_perr;
    logic perr_q, perr_d;
`endif

    // A framed bit restarts the word from any state, so it is handled ahead of the state decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word    = shift_q;
        commit  = 1'b0;
`ifdef SIPO_PARITY_EN
        word_perr = 1'b0;
`endif
        if (serial_valid && frame) begin
            shift_d = {{(DATA_WIDTH-1){1'b0}}, serial_in};
            cnt_d   = CntW'(1);
            state_d = StShift;
        end else if (serial_valid) begin
            case (state_q)
                StShift: begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], serial_in};
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef SIPO_PARITY_EN
                        state_d = StParity;
`else
                        commit  = 1'b1;
                        word    = shift_d;
                        state_d = StIdle;
`endif
                    end
                end
`ifdef SIPO_PARITY_EN
                StParity: begin
                    commit    = 1'b1;
                    word      = shift_q;
                    word_perr = ^{shift_q, serial_in};
                    state_d   = StIdle;
                end
`endif
                default: ;
            endcase
        end
    end

    // A word may land in the same cycle the held one is consumed.
    always_comb begin
        accept    = commit && (!valid_q || out_ready);
        drop      = commit && !accept;
        data_d    = accept ? word : data_q;
        valid_d   = accept ? 1'b1 : (valid_q && !out_ready);
        overrun_d = drop | (overrun_q & ~overrun_clr);
`ifdef SIPO_PARITY_EN
        perr_d    = accept ? word_perr : perr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = data_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomised and directed bench for sipo_deserializer against a bit-queue reference model.
module tb_sipo_deserializer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         frame = 1'b0;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         overrun;
    logic         overrun_clr = 1'b0;
    logic         parity_err;

    int checks = 0;
    int failures = 0;

    // Reference model: bits of the current word kept as a queue, outputs as plain variables.
    bit           m_bits[$];
    bit           m_inword = 1'b0;
    bit           m_par_pend = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;
    logic         exp_overrun = 1'b0;
    logic         exp_perr = 1'b0;

    sipo_deserializer #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame        (frame),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] w = '0;
        foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
        return w;
    endfunction

    task automatic model_step(input bit sv, input bit si, input bit fr, input bit rdy,
                              input bit clr, input bit rst);
        bit           commit = 1'b0;
        bit           drop = 1'b0;
        logic [W-1:0] cw = '0;
        logic         cp = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_inword = 1'b0;
            m_par_pend = 1'b0;
            exp_data = '0;
            exp_valid = 1'b0;
            exp_overrun = 1'b0;
            exp_perr = 1'b0;
            return;
        end
        if (sv) begin
            if (fr) begin
                m_bits.delete();
                m_bits.push_back(si);
                m_inword = 1'b1;
                m_par_pend = 1'b0;
            end else if (m_par_pend) begin
                cw = pack_bits();
                cp = (^cw) ^ si;
                commit = 1'b1;
                m_par_pend = 1'b0;
                m_bits.delete();
            end else if (m_inword) begin
                m_bits.push_back(si);
                if (m_bits.size() == W) begin
                    m_inword = 1'b0;
`ifdef SIPO_PARITY_EN
                    m_par_pend = 1'b1;
`else
                    cw = pack_bits();
                    commit = 1'b1;
                    m_bits.delete();
`endif
                end
            end
        end
        if (commit) begin
            if (!exp_valid || rdy) begin
                exp_data = cw;
                exp_valid = 1'b1;
                exp_perr = cp;
            end else begin
                drop = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        if (drop) exp_overrun = 1'b1;
        else if (clr) exp_overrun = 1'b0;
    endtask

    task automatic step(input bit sv, input bit si, input bit fr, input bit rdy,
                        input bit clr, input bit rst);
        serial_valid = sv;
        serial_in    = si;
        frame        = fr;
        out_ready    = rdy;
        overrun_clr  = clr;
        reset        = rst;
        model_step(sv, si, fr, rdy, clr, rst);
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("parallel_out", parallel_out, exp_data);
        check_eq("overrun", overrun, exp_overrun);
        check_eq("parity_err", parity_err, exp_perr);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    // gap_a/gap_b: 1-based bit index after which 3 idle cycles are inserted (0 = none).
    task automatic send_word(input logic [W-1:0] w, input int gap_a, input int gap_b,
                             input bit rdy, input bit par);
        for (int i = 0; i < W; i++) begin
            step(1, w[W-1-i], i == 0, rdy, 0, 0);
            if (i + 1 == gap_a || i + 1 == gap_b) begin
                for (int g = 0; g < 3; g++) step(0, 0, 0, rdy, 0, 0);
            end
        end
`ifdef SIPO_PARITY_EN
        step(1, par, 0, rdy, 0, 0);
`else
        if (par) step(0, 0, 0, rdy, 0, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] w;

        do_reset();
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_data", parallel_out, 0);

        // Basic word
        w = 16'h3524;
        send_word(w, 0, 0, 1, ^w);
        check_eq("basic_valid", out_valid, 1);
        check_eq("basic_data", parallel_out, 16'h3524);
        step(0, 0, 0, 1, 0, 0);
        check_eq("basic_pulse", out_valid, 0);
        check_eq("basic_overrun", overrun, 0);

        // Gapped input
        w = 16'hA5F0;
        send_word(w, 4, 11, 1, ^w);
        check_eq("gap_data", parallel_out, 16'hA5F0);
        step(0, 0, 0, 1, 0, 0);

        // Frame resync: a partial junk word, then a framed real word
        step(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1'($urandom), 0, 1, 0, 0);
        w = 16'h0F0F;
        send_word(w, 0, 0, 1, ^w);
        check_eq("resync_data", parallel_out, 16'h0F0F);
        step(0, 0, 0, 1, 0, 0);

        // Overrun
        w = 16'h1111;
        send_word(w, 0, 0, 0, ^w);
        w = 16'h2222;
        send_word(w, 0, 0, 0, ^w);
        check_eq("ovr_data", parallel_out, 16'h1111);
        check_eq("ovr_flag", overrun, 1);
        step(0, 0, 0, 0, 1, 0);
        check_eq("ovr_clr", overrun, 0);
        step(0, 0, 0, 1, 0, 0);
        check_eq("ovr_drain", out_valid, 0);

        // Reset mid-word
        for (int i = 0; i < 9; i++) step(1, 1, i == 0, 1, 0, 0);
        do_reset();
        check_eq("rst_data", parallel_out, 0);
        check_eq("rst_valid", out_valid, 0);
        w = 16'h8001;
        send_word(w, 0, 0, 1, ^w);
        check_eq("rst_next", parallel_out, 16'h8001);
        step(0, 0, 0, 1, 0, 0);

`ifdef SIPO_PARITY_EN
        send_word(16'h0003, 0, 0, 1, 0);
        check_eq("par_ok", parity_err, 0);
        send_word(16'h0001, 0, 0, 1, 0);
        check_eq("par_bad", parity_err, 1);
        check_eq("par_valid", out_valid, 1);
        step(0, 0, 0, 1, 0, 0);
`endif

        // Back-to-back random words with random readiness
        for (int k = 0; k < 40; k++) begin
            w = W'($urandom);
            send_word(w, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom));
        end

        // Fully random traffic
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 10) < 7, 1'($urandom), ($urandom % 24) == 0,
                 ($urandom % 3) != 0, ($urandom % 16) == 0, ($urandom % 600) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in parallel-out receiver. It is the far end of the PISO shift-register link.
- Accepts one bit per qualified clock, MSB first, and assembles DATA_WIDTH-bit words.
- Presents each completed word on a held output register with a valid/ready handshake, so it can feed a FIFO or a register bank.
- Frames are aligned with an explicit frame-start strobe. Lost words are reported through a sticky overrun flag.

Parameters:
- DATA_WIDTH, 16, number of data bits per word; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; all state is in this domain.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit, sampled when serial_valid=1.
- serial_valid  input  1  bit strobe; serial_in is consumed on every clk edge where this is 1.
- frame  input  1  qualifies the current bit as the first bit (MSB) of a word; ignored when serial_valid=0.
- parallel_out  output  DATA_WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
- overrun  output  1  sticky; a completed word was dropped because the output was still full.
- overrun_clr  input  1  clears overrun; a new overrun event in the same cycle wins.
- parity_err  output  1  per-word parity status, valid alongside out_valid; tied 0 when the optional feature is disabled.

Behaviour:
- Reset (synchronous, active-high on clk):
  - parallel_out=0, out_valid=0, overrun=0, parity_err=0.
  - Bit counter=0, shift register=0, FSM=IDLE.
  - Reset mid-word discards the partial word and any held output word.
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- IDLE:
  - A bit with serial_valid=1 and frame=0 is discarded.
  - A bit with serial_valid=1 and frame=1 is loaded as the MSB; counter=1; go to SHIFT.
- SHIFT:
  - Each serial_valid=1 shifts serial_in into the LSB end (shift left); counter increments.
  - serial_valid=0 holds state; gaps of any length are allowed.
  - frame=1 with serial_valid=1 restarts the word: the partial word is discarded, the current bit becomes the MSB, counter=1.
  - The DATA_WIDTH-th bit completes the word.
    - Without the optional feature: commit, then go to IDLE.
    - With the optional feature: go to PARITY.
- Commit (the cycle after the completing edge):
  - If out_valid=0, or out_valid=1 and out_ready=1 in the completing cycle: parallel_out takes the word and out_valid=1.
  - Otherwise the word is dropped, overrun is set to 1, and the held word is untouched.
- Latency: out_valid rises on the clk edge that samples the final bit, i.e. visible 1 cycle after the final bit is presented.
- Back-to-back words: the next frame bit may arrive in the cycle directly after the last bit. No dead cycle is required.
- Handshake:
  - out_valid falls after an edge with out_valid=1 and out_ready=1, unless a new word commits on that same edge. In that case out_valid stays 1 with the new data.
  - out_ready while out_valid=0 has no effect.
  - parallel_out holds its last value after a handshake (it is not cleared).
- overrun:
  - Set only by a dropped word.
  - Cleared only by overrun_clr or reset.
  - Set has priority over clear in the same cycle.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - After DATA_WIDTH data bits, the FSM enters PARITY.
  - The next serial_valid bit is an even-parity bit.
  - The commit occurs on that bit. parity_err = XOR(data bits, parity bit), registered with parallel_out.
  - frame=1 in PARITY restarts a new word. The pending word is discarded and not committed.
- When undefined:
  - No PARITY state.
  - A word commits on its DATA_WIDTH-th bit.
  - parity_err is constant 0.

Test Plan:
- Basic word:
  - Stimulus: reset 2 cycles; shift 16'h3524 MSB-first with frame on the first bit, serial_valid=1 continuously, out_ready=1.
  - Response: out_valid pulses 1 cycle, exactly 1 cycle after the 16th bit; parallel_out=16'h3524; overrun=0.
- Gapped input:
  - Stimulus: 16'hA5F0 with serial_valid deasserted 3 cycles after bits 4 and 11.
  - Response: parallel_out=16'hA5F0; out_valid only after the 16th valid bit.
- Frame resync:
  - Stimulus: 7 bits of junk, then frame=1 starting 16'h0F0F.
  - Response: a single word 16'h0F0F; the junk is never output.
- Overrun:
  - Stimulus: out_ready=0; send 16'h1111 then 16'h2222 back-to-back.
  - Response: parallel_out stays 16'h1111 and overrun=1.
  - Then overrun_clr for 1 cycle: overrun=0.
  - Then out_ready=1: out_valid drops.
- Reset mid-word:
  - Stimulus: assert reset after bit 9 of 16'hFFFF; then send 16'h8001.
  - Response: all outputs 0 after reset; the next word output is 16'h8001.
- Parity (SIPO_PARITY_EN defined):
  - Stimulus: 16'h0003 with parity bit 0.
  - Response: parity_err=0.
  - Stimulus: 16'h0001 with parity bit 0.
  - Response: parity_err=1 with out_valid.
